// File: rtl/mdu_unit_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the master side; the MDU is the slave.
interface mdu_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] SA;
  logic [WIDTH-1:0] SB;
  logic [3:0]       MDUOp;
  logic             Start;
  logic             Req;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] MDUOut;

  modport master (
    output SA, SB, MDUOp, Start, Req,
    input  Busy, HI, LO, MDUOut
  );

  modport slave (
    input  SA, SB, MDUOp, Start, Req,
    output Busy, HI, LO, MDUOut
  );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Operands are latched at launch; the result is committed when the cycle counter expires.
module mdu_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic             is_mul, is_div, launch, div_zero;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, s_quo_mag, s_rem_mag, s_quo, s_rem;
  logic [WIDTH-1:0] b_udiv, u_quo, u_rem;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign is_mul = (bus.MDUOp == OpMult) || (bus.MDUOp == OpMultu);
  assign is_div = (bus.MDUOp == OpDiv) || (bus.MDUOp == OpDivu);
  assign launch = (state_q == StIdle) && bus.Start && !bus.Req && (is_mul || is_div);

  assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Signed divide on magnitudes: avoids the MIN/-1 overflow corner and gives
  // truncation toward zero with the remainder following the dividend's sign.
  always_comb begin
    a_neg     = a_q[WIDTH-1];
    b_neg     = b_q[WIDTH-1];
    a_mag     = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    b_mag     = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    if (b_mag == '0) begin
      b_mag = WIDTH'(1);
    end
    s_quo_mag = a_mag / b_mag;
    s_rem_mag = a_mag % b_mag;
    s_quo     = (a_neg ^ b_neg) ? (~s_quo_mag + WIDTH'(1)) : s_quo_mag;
    s_rem     = a_neg ? (~s_rem_mag + WIDTH'(1)) : s_rem_mag;
    b_udiv    = (b_q == '0) ? WIDTH'(1) : b_q;
    u_quo     = a_q / b_udiv;
    u_rem     = a_q % b_udiv;
  end

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OpMult:  {res_hi, res_lo} = prod_s;
      OpMultu: {res_hi, res_lo} = prod_u;
      OpDiv: begin
        res_hi = s_rem;
        res_lo = s_quo;
      end
      OpDivu: begin
        res_hi = u_rem;
        res_lo = u_quo;
      end
      default: ;
    endcase
  end

  assign div_zero = ((op_q == OpDiv) || (op_q == OpDivu)) && (b_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          op_d    = bus.MDUOp;
          a_d     = bus.SA;
          b_d     = bus.SB;
          cnt_d   = is_mul ? CntW'(MUL_CYCLES) : CntW'(DIV_CYCLES);
          state_d = StRun;
        end else if (!bus.Req && bus.MDUOp == OpMthi) begin
          hi_d = bus.SA;
        end else if (!bus.Req && bus.MDUOp == OpMtlo) begin
          lo_d = bus.SA;
        end
      end
      StRun: begin
        // Start, Req and mthi/mtlo are all ignored here: the instruction already left EX.
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (!div_zero) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Busy = (state_q == StRun);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  always_comb begin
    case (bus.MDUOp)
      OpMfhi:  bus.MDUOut = hi_q;
      OpMflo:  bus.MDUOut = lo_q;
      default: bus.MDUOut = '0;
    endcase
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the P7 pipelined MIPS core.
- Runs alongside the ALU and serves mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Exposes Busy so the hazard unit stalls dependent MDU instructions.
- Honours the exception/interrupt request (Req): an instruction flushed in EX must not change architectural HI/LO state.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, Busy duration for mult/multu (must be >= 1).
- DIV_CYCLES, 10, Busy duration for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- SA  input  WIDTH  operand A (rs).
- SB  input  WIDTH  operand B (rt).
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
- Start  input  1  launch the multiply/divide given by MDUOp (1-4).
- Req  input  1  exception/interrupt flush of the EX-stage instruction this cycle.
- Busy  output  1  operation in progress.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.
- MDUOut  output  WIDTH  read data: HI on mfhi, LO on mflo, else 0 (combinational).

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- Reset: Busy=0, HI=0, LO=0, internal counter=0, latched results=0. Reset has priority over every other input, including mid-operation (an in-flight operation is abandoned and its result discarded).
- States:
  - IDLE (Busy=0).
  - RUN (Busy=1, counter counting down).
- Launch: at a rising edge in IDLE with Start=1, Req=0 and MDUOp in 1..4:
  - latch SA, SB and the op;
  - load the counter with MUL_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4);
  - enter RUN.
  - Busy is high from the next cycle for exactly N cycles.
- Start with MDUOp outside 1..4 is ignored.
- Completion: on the edge that ends the Nth RUN cycle:
  - HI/LO take the result;
  - Busy goes 0 on that same edge;
  - the new HI/LO are visible in the first Busy=0 cycle.
- Implementation freedom: the result may be computed combinationally from the latched operands. The counter is the only timing requirement.
- Start while Busy=1 is ignored: no relaunch, no counter reload. The hazard unit stalls on Busy|Start, so this case indicates an upstream bug.
- Req=1 blocks, in that cycle only:
  - a launch;
  - mthi/mtlo writes.
  - It does not abort an operation already in RUN, because that instruction has already passed EX.
- mthi/mtlo: with Busy=0 and Req=0, the next edge writes SA into HI (op 7) or LO (op 8) and leaves the other register untouched. Ignored while Busy=1.
- mfhi/mflo: MDUOut reflects current HI/LO combinationally. During RUN it returns the old value; the pipeline stalls in that case.
- Arithmetic:
  - mult: signed 2*WIDTH product; HI = upper WIDTH bits, LO = lower WIDTH bits.
  - multu: unsigned product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div with the most-negative dividend and -1: LO = most-negative value, HI = 0 (wraps, no trap).
  - divu: unsigned quotient and remainder.
- Divide by zero (div or divu with SB=0): the operation still runs DIV_CYCLES with Busy high. HI and LO are left unchanged at completion.
- Back-to-back operations: a Start in the first Busy=0 cycle launches normally, so one idle cycle separates consecutive operations.
- The unit raises no exceptions (ExcCode stays owned by the ALU/CP0 path).

Test Plan:
- reset, then mult SA=0xFFFFFFFD (-3), SB=5 -> Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. MDUOut on mflo = 0xFFFFFFF1.
- multu SA=0xFFFFFFFF, SB=2 -> after 5 Busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div SA=0xFFFFFFF9 (-7), SB=2 -> Busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div SA=0x80000000, SB=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0x12345678, then divu SA=7, SB=0 -> Busy for 10 cycles; HI stays 0x12345678 and LO is unchanged.
- Req gating and in-flight behaviour:
  - Start=1 with mult and Req=1 -> Busy stays 0, HI/LO unchanged.
  - mtlo 0xAA with Req=1 -> LO unchanged.
  - Start re-asserted mid-RUN with different operands -> ignored; the original result is written at the original cycle.
- Reset and relaunch:
  - reset asserted in the 3rd Busy cycle of a divu -> next cycle Busy=0, HI=LO=0, and no late write occurs.
  - Parameter override MUL_CYCLES=1 -> Busy high for exactly 1 cycle.
